// File: rtl/bitslip_pkg.sv
// Shared lane state encoding and signal polarities for the multi-lane bitslip aligner.
package bitslip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SLIP   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } lane_state_e;

  localparam logic BSP_ENABLE = 1'b1;
  localparam logic BSP_MATCH  = 1'b1;
  localparam logic BSP_FAULT  = 1'b1;

  // A lane counts towards bsp_busy while it is still working on alignment.
  function automatic logic lane_active(input lane_state_e s);
    return (s == ST_SETTLE) || (s == ST_CHECK) || (s == ST_SLIP);
  endfunction

endpackage

// File: rtl/bitslip_lane_fsm.sv
// One alignment lane: settle, compare against two training words, slip until
// locked or out of slip budget.
module bitslip_lane_fsm
  import bitslip_pkg::*;
#(
  parameter int DW       = 16,
  parameter int MAX_SLIP = 8,
  parameter int WAIT_CYC = 16,
  parameter int MATCH_N  = 2,
  parameter int SW       = $clog2(MAX_SLIP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          start,
  input  logic          en,
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] pat0,
  input  logic [DW-1:0] pat1,
  output logic          gen,
  output logic          cmp,
  output logic          err,
  output logic [SW-1:0] slip,
  output logic          active
);

  localparam int WW = $clog2(WAIT_CYC + 1);
  localparam int MW = $clog2(MATCH_N + 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(WAIT_CYC - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(MATCH_N - 1);
  localparam logic [SW-1:0] SLIP_MAX   = SW'(MAX_SLIP);

  lane_state_e   state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [MW-1:0] mcnt, mcnt_n;
  logic [SW-1:0] slip_n;
  logic          gen_n, cmp_n, err_n;
  logic          match;

  assign match  = ((data == pat0) || (data == pat1)) ? BSP_MATCH : ~BSP_MATCH;
  assign active = lane_active(state);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      mcnt     <= '0;
      slip     <= '0;
      gen      <= 1'b0;
      cmp      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      mcnt     <= mcnt_n;
      slip     <= slip_n;
      gen      <= gen_n;
      cmp      <= cmp_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    mcnt_n  = mcnt;
    slip_n  = slip;
    gen_n   = 1'b0;
    cmp_n   = cmp;
    err_n   = err;
    case (state)
      ST_IDLE, ST_LOCKED, ST_FAIL: begin
        if (start && (en == BSP_ENABLE)) begin
          state_n = ST_SETTLE;
          wait_n  = '0;
          mcnt_n  = '0;
          slip_n  = '0;
          cmp_n   = 1'b0;
          err_n   = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (wait_cnt == WAIT_LAST) begin
          state_n = ST_CHECK;
          mcnt_n  = '0;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        if (match == BSP_MATCH) begin
          if (mcnt == MATCH_LAST) begin
            state_n = ST_LOCKED;
            cmp_n   = 1'b1;
          end else begin
            mcnt_n = mcnt + 1'b1;
          end
        end else if (slip < SLIP_MAX) begin
          // gen is registered, so it is high exactly while the lane sits in SLIP.
          state_n = ST_SLIP;
          gen_n   = 1'b1;
          slip_n  = slip + 1'b1;
          mcnt_n  = '0;
        end else begin
          state_n = ST_FAIL;
          err_n   = BSP_FAULT;
          cmp_n   = 1'b0;
          mcnt_n  = '0;
        end
      end
      ST_SLIP: begin
        state_n = ST_SETTLE;
        wait_n  = '0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/bitslip_align_mc.sv
// Multi-lane bitslip aligner: slices lane data to per-lane FSMs and aggregates
// busy/done status.
module bitslip_align_mc
  import bitslip_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DW       = 16,
  parameter int MAX_SLIP = 8,
  parameter int WAIT_CYC = 16,
  parameter int MATCH_N  = 2,
  localparam int SW      = $clog2(MAX_SLIP + 1)
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              bsp_clr,
  input  logic              bsp_start,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [DW-1:0]     bsp_pattern0,
  input  logic [DW-1:0]     bsp_pattern1,
  output logic [NCH-1:0]    bsp_gen,
  output logic [NCH-1:0]    bsp_cmp,
  output logic [NCH-1:0]    bsp_err,
  output logic [NCH*SW-1:0] slip_cnt,
  output logic              bsp_busy,
  output logic              bsp_done
);

  logic [NCH-1:0] active;
  logic           any_active;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    bitslip_lane_fsm #(
      .DW       (DW),
      .MAX_SLIP (MAX_SLIP),
      .WAIT_CYC (WAIT_CYC),
      .MATCH_N  (MATCH_N),
      .SW       (SW)
    ) u_lane (
      .clk    (fclk),
      .rst    (rst),
      .clr    (bsp_clr),
      .start  (bsp_start),
      .en     (ch_en[i]),
      .data   (data_in[i*DW +: DW]),
      .pat0   (bsp_pattern0),
      .pat1   (bsp_pattern1),
      .gen    (bsp_gen[i]),
      .cmp    (bsp_cmp[i]),
      .err    (bsp_err[i]),
      .slip   (slip_cnt[i*SW +: SW]),
      .active (active[i])
    );
  end

  assign any_active = |active;

  // Clear forces busy low, so a clear can never produce a done pulse.
  always_ff @(posedge fclk) begin
    if (!rst || bsp_clr) begin
      bsp_busy <= 1'b0;
      bsp_done <= 1'b0;
    end else begin
      bsp_busy <= any_active;
      bsp_done <= bsp_busy & ~any_active;
    end
  end

endmodule
